vdma_wr_scheduler: RTL and testbench
====================================

VDMA_WR_SCHEDULER -- requirements
Module: vdma_wr_scheduler

Interface
REQ-001 SHALL have parameter DSIZE, default 24, pixel width; sizing only, no data path through this block.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter BURST_LEN, default 64, full-burst beat count (1..255).
REQ-004 SHALL have parameter BPP, default 4, bytes per beat (address step).
REQ-005 SHALL have parameter FB_NUM, default 3, frame buffer count (2..4).
REQ-006 SHALL have port clock, input, 1, sole clock.
REQ-007 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-008 SHALL have port enable, input, 1, run request.
REQ-009 SHALL have port base_addr, input, ADDR_W, buffer 0 start.
REQ-010 SHALL have port frame_stride, input, ADDR_W, bytes between buffers.
REQ-011 SHALL have port line_stride, input, ADDR_W, bytes between lines.
REQ-012 SHALL have ports falign, lalign, ealign, input, 1 each, one-cycle frame-start, line-end and frame-end pulses from the capture port.
REQ-013 SHALL have port data_vld, input, 1, one pixel beat accepted.
REQ-014 SHALL have port rd_fb_idx, input, 2, buffer the reader holds.
REQ-015 SHALL have ports req_vld, output, 1, and req_rdy, input, 1, burst command handshake.
REQ-016 SHALL have ports req_addr, output, ADDR_W, and req_len, output, 8, burst start address and beat count (1..BURST_LEN).
REQ-017 SHALL have port burst_done, input, 1, one pulse per completed burst.
REQ-018 SHALL have ports wr_fb_idx, output, 2; frame_done, output, 1 (pulse); busy, output, 1; err_ovf, output, 1.

Function
REQ-019 SHALL run FSM IDLE -> ARMED (enable=1) -> ACTIVE (falign) -> DRAIN (ealign) -> ARMED, or IDLE if enable=0.
REQ-020 SHALL, in ACTIVE, count data_vld beats in col_cnt; at col_cnt==BURST_LEN-1 with data_vld, push one command {addr, BURST_LEN} and clear the burst beat count.
REQ-021 SHALL compute addr = base_addr + wr_fb_idx*frame_stride + line*line_stride + burst_start_col*BPP, modulo 2^ADDR_W.
REQ-022 SHALL, on lalign with residue r>0, push {addr, r}; SHALL then increment line and zero the column counters; r==0 pushes nothing.
REQ-023 SHALL process data_vld before lalign when both occur in the same cycle.
REQ-024 SHALL queue commands in a 4-deep FIFO; req_vld = FIFO non-empty; pop on req_vld&req_rdy; req_addr/req_len stable while req_vld=1 and req_rdy=0.
REQ-025 SHALL track outstanding = pushed - burst_done and stay in DRAIN until FIFO is empty and outstanding==0, then pulse frame_done for 1 cycle.
REQ-026 SHALL, at frame_done, advance wr_fb_idx modulo FB_NUM, skipping rd_fb_idx; wr_fb_idx never equals rd_fb_idx after advance.
REQ-027 SHALL, on falign while in ACTIVE, restart line/column counts with the same wr_fb_idx and issue no frame_done.
REQ-028 SHALL ignore falign/lalign/data_vld in IDLE, ARMED (except falign) and DRAIN.
REQ-029 SHALL hold busy=1 in ACTIVE and DRAIN.
REQ-030 SHALL, on enable=0 in ACTIVE, finish the frame normally before IDLE.

Reset
REQ-031 SHALL, with rst_n=0 at a clock edge, enter IDLE and zero all counters, FIFO, wr_fb_idx, req_vld, frame_done, busy and err_ovf, including mid-burst; outstanding bursts are forgotten.

Configuration
REQ-032 SHALL, with VDMA_WR_OVF_CHK_EN defined, on a push to a full FIFO drop the command and set err_ovf sticky until reset.
REQ-033 SHALL, without VDMA_WR_OVF_CHK_EN, tie err_ovf to 0; overflow is then undefined.

Structure
REQ-034 SHALL place the FSM state enum and FIFO depth constant in package vdma_pkg.
REQ-035 SHALL implement the command queue as sub-module wr_cmd_fifo.

Verification
REQ-036 SHALL cover: hactive=128, vactive=2, BURST_LEN=64, req_rdy=1 -> 4 commands len 64, addrs base+0, +256, +line_stride, +line_stride+256; then frame_done.
REQ-037 SHALL cover: hactive=100 -> per line len 64 then len 36 at +256.
REQ-038 SHALL cover: FB_NUM=3, rd_fb_idx=1, three frames -> wr_fb_idx sequence 0,2,0,2.
REQ-039 SHALL cover: req_rdy=0 for 6 commands with VDMA_WR_OVF_CHK_EN -> err_ovf=1 after the 5th push, queue holds 4.
REQ-040 SHALL cover: burst_done withheld for 20 cycles after the last pop -> frame_done delayed 20 cycles, busy=1 throughout.
REQ-041 SHALL cover: rst_n=0 mid-line with req_vld=1 -> next cycle req_vld=0, IDLE, wr_fb_idx=0.

Source files
------------

// File: rtl/vdma_pkg.sv
// ---------------------------------------------------------------------------
// vdma_pkg
// Shared definitions for the VDMA write-side burst scheduler:
//   - wr_state_t      : scheduler FSM states
//   - CMD_FIFO_DEPTH  : depth of the burst command queue (power of two)
//   - CMD_FIFO_AW     : pointer width for that queue
//   - fb_advance()    : next write frame buffer, skipping the reader's one
// ---------------------------------------------------------------------------
package vdma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } wr_state_t;

  localparam int CMD_FIFO_DEPTH = 4;
  localparam int CMD_FIFO_AW    = 2;

  // Step to the next buffer modulo fb_num; if that is the one the reader
  // holds, step once more. With fb_num >= 2 the result never equals rd.
  function automatic logic [1:0] fb_advance(input logic [1:0] cur,
                                            input logic [1:0] rd,
                                            input logic [2:0] fb_num);
    logic [2:0] nxt;
    nxt = {1'b0, cur} + 3'd1;
    if (nxt >= fb_num) nxt = 3'd0;
    if (nxt[1:0] == rd) begin
      nxt = nxt + 3'd1;
      if (nxt >= fb_num) nxt = 3'd0;
    end
    return nxt[1:0];
  endfunction

endpackage

// File: rtl/wr_cmd_fifo.sv
// ---------------------------------------------------------------------------
// wr_cmd_fifo
// Small show-ahead command queue (CMD_FIFO_DEPTH entries) for burst commands.
// The head entry is presented combinationally so it stays stable until popped.
// Ports:
//   clock      in   sole clock
//   rst_n      in   synchronous active-low reset (empties the queue)
//   i_wr_en    in   push i_wr_data (ignored when full and not popping)
//   i_wr_data  in   W-bit command word
//   i_rd_en    in   pop head entry (ignored when empty)
//   o_rd_data  out  head entry
//   o_empty    out  queue empty
//   o_full     out  queue full
// ---------------------------------------------------------------------------
module wr_cmd_fifo
  import vdma_pkg::*;
#(
  parameter int W = 40
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_empty,
  output logic         o_full
);

  logic [W-1:0]           r_mem [CMD_FIFO_DEPTH];
  logic [CMD_FIFO_AW-1:0] r_wr_ptr;
  logic [CMD_FIFO_AW-1:0] r_rd_ptr;
  logic [CMD_FIFO_AW:0]   r_count;
  logic                   w_wr;
  logic                   w_rd;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (CMD_FIFO_AW+1)'(CMD_FIFO_DEPTH));
  assign w_rd      = i_rd_en & ~o_empty;
  // A push into a full queue is accepted only when the head leaves this cycle.
  assign w_wr      = i_wr_en & (~o_full | w_rd);
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + CMD_FIFO_AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + CMD_FIFO_AW'(1);
      r_count <= r_count + {{CMD_FIFO_AW{1'b0}}, w_wr} - {{CMD_FIFO_AW{1'b0}}, w_rd};
    end
  end

endmodule

// File: rtl/vdma_wr_scheduler.sv
// ---------------------------------------------------------------------------
// vdma_wr_scheduler
// Turns capture-port timing pulses into AXI-style write burst commands for a
// multi-buffered frame store. Pixel data does not pass through this block.
// Optional feature: define VDMA_WR_OVF_CHK_EN to drop commands pushed into a
// full queue and raise a sticky err_ovf; otherwise err_ovf is tied low.
// Ports:
//   clock, rst_n                 sole clock; synchronous active-low reset
//   enable                       run request
//   base_addr                    byte address of buffer 0
//   frame_stride, line_stride    bytes between buffers / between lines
//   falign, lalign, ealign       frame-start, line-end, frame-end pulses
//   data_vld                     one pixel beat accepted by the capture port
//   rd_fb_idx                    buffer currently held by the reader
//   req_vld/req_rdy              burst command handshake
//   req_addr, req_len            burst start address and beat count
//   burst_done                   one pulse per completed burst
//   wr_fb_idx                    buffer being written
//   frame_done                   one-cycle pulse when a frame is fully written
//   busy                         frame in progress or draining
//   err_ovf                      sticky command queue overflow
// ---------------------------------------------------------------------------
module vdma_wr_scheduler
  import vdma_pkg::*;
#(
  parameter int DSIZE     = 24,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 64,
  parameter int BPP       = 4,
  parameter int FB_NUM    = 3
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] frame_stride,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic              falign,
  input  logic              lalign,
  input  logic              ealign,
  input  logic              data_vld,
  input  logic [1:0]        rd_fb_idx,
  output logic              req_vld,
  input  logic              req_rdy,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_len,
  input  logic              burst_done,
  output logic [1:0]        wr_fb_idx,
  output logic              frame_done,
  output logic              busy,
  output logic              err_ovf
);

  localparam int                CMD_W          = ADDR_W + 8;
  localparam logic [7:0]        LP_LEN_FULL    = 8'(BURST_LEN);
  localparam logic [7:0]        LP_LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LP_BURST_BYTES = ADDR_W'(BURST_LEN * BPP);
  localparam logic [2:0]        LP_FB_NUM      = 3'(FB_NUM);

  generate
    if (DSIZE < 1 || BURST_LEN < 1 || BURST_LEN > 255 || BPP < 1 ||
        FB_NUM < 2 || FB_NUM > 4) begin : g_param_chk
      $error("vdma_wr_scheduler: parameter out of range");
    end
  endgenerate

  wr_state_t         r_state;
  wr_state_t         w_state_next;
  logic [ADDR_W-1:0] r_line_base;   // buffer base + line * line_stride
  logic [ADDR_W-1:0] r_col_off;     // byte offset of current burst's first beat
  logic [7:0]        r_col_cnt;     // beats collected in the current burst
  logic [7:0]        r_outst;       // pushed commands not yet completed
  logic [1:0]        r_wr_fb_idx;
  logic              r_frame_done;

  logic              w_active;
  logic              w_start;
  logic              w_restart;
  logic              w_beat;
  logic              w_full_burst;
  logic              w_line_end;
  logic [7:0]        w_residue;
  logic              w_push;
  logic              w_push_ok;
  logic [7:0]        w_push_len;
  logic [ADDR_W-1:0] w_push_addr;
  logic [ADDR_W-1:0] w_frame_off;
  logic              w_pop;
  logic              w_bd;
  logic              w_frame_end;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [CMD_W-1:0]  w_fifo_rdata;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_IDLE:   if (enable) w_state_next = ST_ARMED;
      ST_ARMED: begin
        if (!enable)     w_state_next = ST_IDLE;
        else if (falign) w_state_next = ST_ACTIVE;
      end
      // enable is deliberately not looked at here: a running frame completes.
      ST_ACTIVE: if (ealign) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (w_fifo_empty && (r_outst == 8'd0)) begin
          w_frame_end  = 1'b1;
          w_state_next = enable ? ST_ARMED : ST_IDLE;
        end
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- command generation ----------------
  assign w_active  = (r_state == ST_ACTIVE);
  assign w_start   = (r_state == ST_ARMED) & enable & falign;
  // A repeated frame start discards the partial frame; frame end wins over it.
  assign w_restart = w_active & falign & ~ealign;
  assign w_beat       = w_active & data_vld & ~w_restart;
  assign w_full_burst = w_beat & (r_col_cnt == LP_LAST_BEAT);
  // Residue counts this cycle's beat first, so a line end coinciding with the
  // last beat sees the complete line.
  assign w_residue    = w_full_burst ? 8'd0 : (r_col_cnt + {7'd0, w_beat});
  assign w_line_end   = w_active & lalign & ~w_restart;
  assign w_push       = w_full_burst | (w_line_end & (w_residue != 8'd0));
  assign w_push_len   = w_full_burst ? LP_LEN_FULL : w_residue;
  assign w_push_addr  = r_line_base + r_col_off;

  // idx * frame_stride for a 2-bit idx, without a general multiplier.
  assign w_frame_off = ({ADDR_W{r_wr_fb_idx[0]}} & frame_stride) +
                       ({ADDR_W{r_wr_fb_idx[1]}} & {frame_stride[ADDR_W-2:0], 1'b0});

  assign w_pop     = ~w_fifo_empty & req_rdy;
  assign w_push_ok = w_push & (~w_fifo_full | w_pop);
  assign w_bd      = burst_done & (r_outst != 8'd0);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_line_base  <= '0;
      r_col_off    <= '0;
      r_col_cnt    <= '0;
      r_outst      <= '0;
      r_wr_fb_idx  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_start || w_restart) begin
        r_line_base <= base_addr + w_frame_off;
        r_col_off   <= '0;
        r_col_cnt   <= '0;
      end else if (w_line_end) begin
        r_line_base <= r_line_base + line_stride;
        r_col_off   <= '0;
        r_col_cnt   <= '0;
      end else if (w_full_burst) begin
        r_col_cnt <= '0;
        r_col_off <= r_col_off + LP_BURST_BYTES;
      end else if (w_beat) begin
        r_col_cnt <= r_col_cnt + 8'd1;
      end

      r_outst <= r_outst + {7'd0, w_push_ok} - {7'd0, w_bd};

      if (w_frame_end) r_wr_fb_idx <= fb_advance(r_wr_fb_idx, rd_fb_idx, LP_FB_NUM);
      r_frame_done <= w_frame_end;
    end
  end

`ifdef VDMA_WR_OVF_CHK_EN
  logic r_err_ovf;
  logic w_ovf;
  assign w_ovf = w_push & w_fifo_full & ~w_pop;
  always_ff @(posedge clock) begin
    if (!rst_n)     r_err_ovf <= 1'b0;
    else if (w_ovf) r_err_ovf <= 1'b1;
  end
  assign err_ovf = r_err_ovf;
`else
  assign err_ovf = 1'b0;
`endif

  wr_cmd_fifo #(
    .W (CMD_W)
  ) u_cmd_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .i_wr_en   (w_push_ok),
    .i_wr_data ({w_push_addr, w_push_len}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rdata),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  assign req_vld    = ~w_fifo_empty;
  assign req_addr   = w_fifo_rdata[CMD_W-1:8];
  assign req_len    = w_fifo_rdata[7:0];
  assign wr_fb_idx  = r_wr_fb_idx;
  assign frame_done = r_frame_done;
  assign busy       = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);

endmodule

// File: tb/tb_vdma_wr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vdma_wr_scheduler
// Scoreboard bench: every command the bench expects is queued while the pixel
// stream is driven and compared when the scheduler hands it out.
// ---------------------------------------------------------------------------
module tb_vdma_wr_scheduler;

  localparam int ADDR_W    = 32;
  localparam int BURST_LEN = 64;
  localparam int BPP       = 4;
  localparam int FB_NUM    = 3;
  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [31:0] FSTRIDE = 32'h0010_0000;
  localparam logic [31:0] LSTRIDE = 32'h0000_1000;
`ifdef VDMA_WR_OVF_CHK_EN
  localparam int OVF_BURSTS = 6;
`else
  localparam int OVF_BURSTS = 4;
`endif

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] base_addr = BASE;
  logic [ADDR_W-1:0] frame_stride = FSTRIDE;
  logic [ADDR_W-1:0] line_stride = LSTRIDE;
  logic              falign = 1'b0, lalign = 1'b0, ealign = 1'b0, data_vld = 1'b0;
  logic [1:0]        rd_fb_idx = 2'd1;
  logic              req_vld, req_rdy = 1'b1;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              burst_done = 1'b0;
  logic [1:0]        wr_fb_idx;
  logic              frame_done, busy, err_ovf;

  always #5 clock = ~clock;

  vdma_wr_scheduler #(
    .DSIZE(24), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .BPP(BPP), .FB_NUM(FB_NUM)
  ) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable),
    .base_addr(base_addr), .frame_stride(frame_stride), .line_stride(line_stride),
    .falign(falign), .lalign(lalign), .ealign(ealign), .data_vld(data_vld),
    .rd_fb_idx(rd_fb_idx), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_addr(req_addr), .req_len(req_len), .burst_done(burst_done),
    .wr_fb_idx(wr_fb_idx), .frame_done(frame_done), .busy(busy), .err_ovf(err_ovf)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  cmd_t exp_q[$];
  int   due_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc = 0;
  int   bd_lat = 2;
  int   last_pop_cyc = 0, fd_cyc = 0, fd_count = 0, pop_count = 0;
  int   busy_low = 0;
  bit   watch_busy = 1'b0;
  int   held = 0;
  int   m_fb = 0, m_line = 0, m_start = 0, m_beats = 0;

  task automatic tb_check(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] addr_of(int fb, int line, int col);
    return BASE + 32'(fb) * FSTRIDE + 32'(line) * LSTRIDE + 32'(col * BPP);
  endfunction

  // Output monitor: handshakes, burst completion responder, frame_done, busy.
  initial begin
    cmd_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (req_vld && req_rdy) begin
        pop_count++;
        last_pop_cyc = cyc;
        $display("cmd  addr=0x%08h len=%0d  t=%0t", req_addr, req_len, $time);
        if (exp_q.size() == 0) begin
          tb_check("unexpected_cmd", 64'(req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          tb_check("req_addr", 64'(req_addr), 64'(e.addr));
          tb_check("req_len", 64'(req_len), 64'(e.len));
        end
        due_q.push_back(cyc + bd_lat);
      end
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        burst_done = 1'b1;
        void'(due_q.pop_front());
      end else begin
        burst_done = 1'b0;
      end
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (watch_busy && !busy && !frame_done) busy_low++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(logic [31:0] a, int len);
    cmd_t c;
    c.addr = a;
    c.len  = 8'(len);
    // While the consumer stalls, only the first four commands fit the queue.
    if (req_rdy) exp_q.push_back(c);
    else begin
      if (held < 4) exp_q.push_back(c);
      held++;
    end
  endtask

  task automatic close_line();
    if (m_beats > 0) push_exp(addr_of(m_fb, m_line, m_start), m_beats);
    m_line++;
    m_start = 0;
    m_beats = 0;
  endtask

  task automatic beat(bit with_lalign);
    data_vld = 1'b1;
    lalign   = with_lalign;
    m_beats++;
    if (m_beats == BURST_LEN) begin
      push_exp(addr_of(m_fb, m_line, m_start), BURST_LEN);
      m_start += BURST_LEN;
      m_beats = 0;
    end
    step();
    data_vld = 1'b0;
    lalign   = 1'b0;
    if (with_lalign) close_line();
  endtask

  task automatic line_end();
    lalign = 1'b1;
    step();
    lalign = 1'b0;
    close_line();
  endtask

  task automatic drive_line(int hactive, bit merge);
    for (int i = 0; i < hactive; i++) beat(merge && (i == hactive - 1));
    if (!merge) line_end();
    step();
  endtask

  task automatic start_frame(int fb);
    tb_check("fb_idx_at_start", 64'(wr_fb_idx), 64'(fb));
    m_fb = fb; m_line = 0; m_start = 0; m_beats = 0;
    falign = 1'b1;
    step();
    falign = 1'b0;
    tb_check("busy_active", 64'(busy), 64'd1);
  endtask

  task automatic end_frame();
    ealign = 1'b1;
    step();
    ealign = 1'b0;
  endtask

  task automatic wait_frame_done(string tag);
    int start_cnt;
    int t;
    start_cnt = fd_count;
    t = 0;
    while (fd_count == start_cnt && t < 3000) begin
      step();
      t++;
    end
    tb_check({tag, "_frame_done"}, 64'(fd_count - start_cnt), 64'd1);
  endtask

  initial begin
    int p0;
    // ---------------- reset ----------------
    repeat (3) step();
    tb_check("rst_req_vld", 64'(req_vld), 64'd0);
    tb_check("rst_busy", 64'(busy), 64'd0);
    tb_check("rst_frame_done", 64'(frame_done), 64'd0);
    tb_check("rst_wr_fb_idx", 64'(wr_fb_idx), 64'd0);
    tb_check("rst_err_ovf", 64'(err_ovf), 64'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (2) step();
    tb_check("armed_not_busy", 64'(busy), 64'd0);

    // Frame A: 128 x 2, four full bursts.
    start_frame(0);
    for (int l = 0; l < 2; l++) drive_line(128, 1'b0);
    end_frame();
    wait_frame_done("frameA");
    tb_check("fb_after_A", 64'(wr_fb_idx), 64'd2);
    tb_check("queue_empty_A", 64'(exp_q.size()), 64'd0);

    // Frame B: 100 x 2, full burst + 36-beat residue per line; the second
    // line end coincides with its last beat.
    start_frame(2);
    drive_line(100, 1'b0);
    drive_line(100, 1'b1);
    end_frame();
    wait_frame_done("frameB");
    tb_check("fb_after_B", 64'(wr_fb_idx), 64'd0);
    tb_check("queue_empty_B", 64'(exp_q.size()), 64'd0);

    // Frame C: completions held back 20 cycles after the single pop.
    bd_lat = 20;
    start_frame(0);
    drive_line(64, 1'b0);
    end_frame();
    busy_low   = 0;
    watch_busy = 1'b1;
    wait_frame_done("frameC");
    watch_busy = 1'b0;
    // burst_done at pop+20, outstanding clears on that edge, frame_done is
    // registered one edge later and seen at the following sample: pop+22.
    tb_check("frameC_done_delay", 64'(fd_cyc - last_pop_cyc), 64'd22);
    tb_check("frameC_busy_held", 64'(busy_low), 64'd0);
    tb_check("fb_after_C", 64'(wr_fb_idx), 64'd2);
    bd_lat = 2;

    // Reset mid-line with a command waiting.
    req_rdy = 1'b0;
    held    = 0;
    start_frame(2);
    for (int i = 0; i < 70; i++) beat(1'b0);
    tb_check("pre_rst_req_vld", 64'(req_vld), 64'd1);
    rst_n = 1'b0;
    step();
    tb_check("midrst_req_vld", 64'(req_vld), 64'd0);
    tb_check("midrst_busy", 64'(busy), 64'd0);
    tb_check("midrst_wr_fb_idx", 64'(wr_fb_idx), 64'd0);
    tb_check("midrst_frame_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    due_q.delete();
    repeat (3) step();

    // Queue depth / overflow with the consumer stalled.
    held = 0;
    start_frame(0);
    for (int b = 0; b < OVF_BURSTS; b++) begin
      for (int i = 0; i < BURST_LEN; i++) beat(1'b0);
      tb_check("err_ovf_after_push", 64'(err_ovf), 64'(b >= 4));
    end
    tb_check("stall_req_vld", 64'(req_vld), 64'd1);
    line_end();
    end_frame();
    p0 = pop_count;
    req_rdy = 1'b1;
    wait_frame_done("frameOvf");
    tb_check("queue_depth_pops", 64'(pop_count - p0), 64'd4);
    tb_check("err_ovf_sticky", 64'(err_ovf), 64'(OVF_BURSTS > 4));
    tb_check("fb_after_ovf", 64'(wr_fb_idx), 64'd2);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
